// File: rtl/serial_shifter_if.sv
// rtl/serial_shifter_if.sv - start/busy/done handshake bundle for the serial shifter
//
// Purpose: groups the request operands and the result/handshake outputs of
//          serial_shifter so the execute-stage controller connects with one port.
// Signals:
//   start - request, sampled only while the shifter is ready (IDLE or DONE)
//   In    - N-bit operand, captured on an accepted start
//   Cnt   - C-bit shift amount, captured on an accepted start
//   Op    - 00 ROR, 01 SLL, 10 SRA, 11 SRL, captured on an accepted start
//   Out   - N-bit result register, updated only on entry to DONE
//   busy  - high while shifting; start is ignored then
//   done  - one-cycle pulse, result valid on Out
// Modports: master (controller side), slave (shifter side).

interface serial_shifter_if #(
    parameter int N = 16,
    parameter int C = 4
);
    logic         start;
    logic [N-1:0] In;
    logic [C-1:0] Cnt;
    logic [1:0]   Op;
    logic [N-1:0] Out;
    logic         busy;
    logic         done;

    modport master (
        output start, In, Cnt, Op,
        input  Out, busy, done
    );

    modport slave (
        input  start, In, Cnt, Op,
        output Out, busy, done
    );
endinterface

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - bit-serial rotate/shift unit, one bit position per clock
//
// Purpose: multi-cycle functional unit beside the ALU providing rotate-right,
//          logical left/right and arithmetic right shifts by 0..N-1 positions.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset; discards any in-flight operation
//   bus - serial_shifter_if.slave: start/In/Cnt/Op in, Out/busy/done out
// Behaviour summary:
//   An accepted start loads the operand, count and opcode. A zero count goes
//   straight to DONE with Out = In; otherwise one single-bit step is applied
//   per clock in SHIFT until the count is exhausted. done pulses for one cycle
//   and a start in that cycle is accepted, so operations can run back to back.

module serial_shifter #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic            clk,
    input  logic            rst,
    serial_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    state_t       r_state;
    logic [N-1:0] r_sr;
    logic [C-1:0] r_cnt;
    logic [1:0]   r_op;
    logic [N-1:0] r_out;

    state_t       w_state_nxt;
    logic [N-1:0] w_sr_nxt;
    logic [C-1:0] w_cnt_nxt;
    logic [1:0]   w_op_nxt;
    logic [N-1:0] w_out_nxt;
    logic [N-1:0] w_step;
    logic         w_ready;

    // One single-bit step of the shift register for the latched opcode.
    always_comb begin
        w_step = r_sr;
        case (r_op)
            OP_ROR:  w_step = {r_sr[0], r_sr[N-1:1]};
            OP_SLL:  w_step = {r_sr[N-2:0], 1'b0};
            OP_SRA:  w_step = {r_sr[N-1], r_sr[N-1:1]};
            OP_SRL:  w_step = {1'b0, r_sr[N-1:1]};
            default: w_step = r_sr;
        endcase
    end

    // DONE behaves like IDLE for acceptance so a new request can follow
    // the done pulse without an idle gap.
    assign w_ready = (r_state == IDLE) || (r_state == DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_out_nxt   = r_out;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_sr_nxt  = bus.In;
                    w_cnt_nxt = bus.Cnt;
                    w_op_nxt  = bus.Op;
                    if (bus.Cnt == '0) begin
                        w_out_nxt   = bus.In;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end else if (r_state == DONE) begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                w_sr_nxt  = w_step;
                w_cnt_nxt = r_cnt - 1'b1;
                // cnt==1 marks the final step: publish the stepped value
                // directly so Out never shows an intermediate result.
                if (r_cnt == {{(C-1){1'b0}}, 1'b1}) begin
                    w_out_nxt   = w_step;
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign bus.Out  = r_out;
    assign bus.busy = (r_state == SHIFT);
    assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_serial_shifter.sv
// tb/tb_serial_shifter.sv - self-checking bench for serial_shifter

module tb_serial_shifter;

    logic clk;
    logic rst;

    serial_shifter_if #(.N(16), .C(4)) bus ();

    serial_shifter #(.N(16), .C(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [15:0] exp_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from the arithmetic meaning of each opcode.
    function automatic logic [15:0] model(input logic [15:0] a, input int n, input logic [1:0] o);
        logic [31:0]        dbl;
        logic signed [15:0] s;
        dbl = {a, a} >> n;
        s   = a;
        case (o)
            2'b00:   return dbl[15:0];
            2'b01:   return a << n;
            2'b10:   return 16'(s >>> n);
            default: return a >> n;
        endcase
    endfunction

    // Issues one request from a negedge, then follows it to done.
    // intrude > 0 pulses a second start with In=FFFF at that cycle after acceptance.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [3:0] c,
                         input logic [1:0] o, input int intrude);
        logic [15:0] exp;
        int          lat;
        int          nb;
        bit          stable;
        bit          seen;
        exp = model(a, int'(c), o);
        bus.start = 1'b1;
        bus.In    = a;
        bus.Cnt   = c;
        bus.Op    = o;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.In    = 16'($urandom);
        bus.Cnt   = 4'($urandom);
        bus.Op    = 2'($urandom);
        lat = 0; nb = 0; stable = 1'b1; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy === 1'b1) nb++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.Out !== exp_out) stable = 1'b0;
                if (intrude != 0 && lat == intrude) begin
                    bus.start = 1'b1;
                    bus.In    = 16'hFFFF;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"},   32'(lat),  32'(int'(c) + 1));
        chk({tag, "_busy_cyc"},  32'(nb),   32'(c));
        chk({tag, "_out"},       32'(bus.Out), 32'(exp));
        chk({tag, "_out_held"},  32'(stable), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        exp_out = exp;
    endtask

    initial begin
        int          ndone;
        logic [15:0] ra;
        logic [3:0]  rc;
        logic [1:0]  ro;
        int          gap;

        checks  = 0;
        errors  = 0;
        exp_out = 16'h0000;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.In    = 16'h5A5A;
        bus.Cnt   = 4'd3;
        bus.Op    = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out",  32'(bus.Out),  32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);

        do_op("ror1", 16'h8001, 4'd1, 2'b00, 0);
        @(negedge clk);
        do_op("sra15", 16'h8000, 4'd15, 2'b10, 0);
        @(negedge clk);
        do_op("srl15", 16'h8000, 4'd15, 2'b11, 0);
        @(negedge clk);
        do_op("zero_cnt", 16'h1234, 4'd0, 2'b01, 0);
        @(negedge clk);

        do_op("ign_busy", 16'h00F0, 4'd4, 2'b01, 2);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        chk("ign_busy_no_second", 32'(ndone), 32'd0);

        do_op("b2b_first", 16'h0003, 4'd2, 2'b00, 0);
        do_op("b2b_second", 16'h0003, 4'd2, 2'b00, 0);
        @(negedge clk);

        bus.start = 1'b1;
        bus.In    = 16'hAAAA;
        bus.Cnt   = 4'd8;
        bus.Op    = 2'b11;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_mid_out",  32'(bus.Out),  32'h0);
        chk("rst_mid_busy", 32'(bus.busy), 32'h0);
        chk("rst_mid_done", 32'(bus.done), 32'h0);
        exp_out = 16'h0000;
        @(negedge clk);
        chk("rst_start_ignored", 32'(bus.busy | bus.done), 32'h0);
        do_op("after_rst", 16'h0002, 4'd1, 2'b11, 0);

        for (int i = 0; i < 30; i++) begin
            ra  = 16'($urandom);
            rc  = 4'($urandom);
            ro  = 2'($urandom);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            do_op($sformatf("rand%0d", i), ra, rc, ro, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
